// File: rtl/tpc_sram_arbiter.sv
// Banked scratchpad SRAM arbiter: XOR-swizzled bank decode, per-bank round-robin grant, 1-cycle read return.
// Optional per-requester conflict and per-bank access counters when TPC_SRAM_ARB_PERF_EN is defined.
module tpc_sram_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned SRAM_BANKS = 4,
  parameter int unsigned SRAM_DEPTH = 256,
  parameter int unsigned SRAM_WIDTH = 256,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  input  logic [NUM_REQ-1:0]                        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]                 req_addr,
  input  logic [NUM_REQ*SRAM_WIDTH-1:0]             req_wdata,
  output logic [NUM_REQ-1:0]                        req_gnt,
  output logic [NUM_REQ-1:0]                        rsp_valid,
  output logic [NUM_REQ*SRAM_WIDTH-1:0]             rsp_data,
  output logic [SRAM_BANKS-1:0]                     bank_en,
  output logic [SRAM_BANKS-1:0]                     bank_we,
  output logic [SRAM_BANKS*$clog2(SRAM_DEPTH)-1:0]  bank_word,
  output logic [SRAM_BANKS*SRAM_WIDTH-1:0]          bank_wdata,
  input  logic [SRAM_BANKS*SRAM_WIDTH-1:0]          bank_rdata
`ifdef TPC_SRAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]                     perf_conflict,
  output logic [SRAM_BANKS*32-1:0]                  perf_access
`endif
);

  localparam int unsigned BB   = $clog2(SRAM_BANKS);
  localparam int unsigned WB   = $clog2(SRAM_DEPTH);
  localparam int unsigned RR_W = $clog2(NUM_REQ);
  localparam int unsigned HI   = BB + WB;

  logic [BB-1:0]   req_bank [NUM_REQ];
  logic [WB-1:0]   req_word [NUM_REQ];
  logic [RR_W-1:0] rr_ptr   [SRAM_BANKS];
  logic [RR_W-1:0] next_ptr [SRAM_BANKS];
  logic [RR_W-1:0] win_idx  [SRAM_BANKS];
  logic [RR_W-1:0] rd_owner [SRAM_BANKS];
  logic [SRAM_BANKS-1:0] win_vld;
  logic [SRAM_BANKS-1:0] rd_pend;
  logic unused_addr_hi;

  always_comb begin
    unused_addr_hi = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_bank[r] = req_addr[r*ADDR_W +: BB] ^ req_addr[r*ADDR_W+WB +: BB];
      req_word[r] = req_addr[r*ADDR_W+BB +: WB];
      for (int unsigned i = HI; i < ADDR_W; i++)
        unused_addr_hi = unused_addr_hi ^ req_addr[r*ADDR_W+i];
    end
  end

  // Scan slot k selects requester (rr_ptr+k) mod NUM_REQ; matching against a
  // constant r keeps every index static.
  always_comb begin : arbitrate
    int unsigned idx;
    idx        = 0;
    win_vld    = '0;
    req_gnt    = '0;
    bank_en    = '0;
    bank_we    = '0;
    bank_word  = '0;
    bank_wdata = '0;
    for (int unsigned b = 0; b < SRAM_BANKS; b++) begin
      win_idx[b]  = '0;
      next_ptr[b] = '0;
    end
    for (int unsigned b = 0; b < SRAM_BANKS; b++) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(rr_ptr[b]) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
          if (r == idx && !rst && !win_vld[b] && req_valid[r] && req_bank[r] == BB'(b)) begin
            win_vld[b]  = 1'b1;
            win_idx[b]  = RR_W'(r);
            next_ptr[b] = RR_W'((r + 1 == NUM_REQ) ? 0 : r + 1);
            req_gnt[r]  = 1'b1;
            bank_en[b]  = 1'b1;
            bank_we[b]  = req_we[r];
            bank_word[b*WB +: WB] = req_word[r];
            bank_wdata[b*SRAM_WIDTH +: SRAM_WIDTH] = req_wdata[r*SRAM_WIDTH +: SRAM_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= '0;
      for (int unsigned b = 0; b < SRAM_BANKS; b++) begin
        rr_ptr[b]   <= '0;
        rd_owner[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < SRAM_BANKS; b++) begin
        if (win_vld[b]) rr_ptr[b] <= next_ptr[b];
        rd_pend[b]  <= win_vld[b] && !bank_we[b];
        rd_owner[b] <= win_idx[b];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int unsigned b = 0; b < SRAM_BANKS; b++) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (rd_pend[b] && rd_owner[b] == RR_W'(r)) begin
          rsp_valid[r] = 1'b1;
          rsp_data[r*SRAM_WIDTH +: SRAM_WIDTH] = rsp_data[r*SRAM_WIDTH +: SRAM_WIDTH]
                                               | bank_rdata[b*SRAM_WIDTH +: SRAM_WIDTH];
        end
      end
    end
  end

`ifdef TPC_SRAM_ARB_PERF_EN
  logic [31:0] conflict_cnt [NUM_REQ];
  logic [31:0] access_cnt   [SRAM_BANKS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) conflict_cnt[r] <= '0;
      for (int unsigned b = 0; b < SRAM_BANKS; b++) access_cnt[b] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++)
        if (req_valid[r] && !req_gnt[r] && conflict_cnt[r] != '1)
          conflict_cnt[r] <= conflict_cnt[r] + 32'd1;
      for (int unsigned b = 0; b < SRAM_BANKS; b++)
        if (bank_en[b] && access_cnt[b] != '1)
          access_cnt[b] <= access_cnt[b] + 32'd1;
    end
  end

  always_comb begin
    perf_conflict = '0;
    perf_access   = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) perf_conflict[r*32 +: 32] = conflict_cnt[r];
    for (int unsigned b = 0; b < SRAM_BANKS; b++) perf_access[b*32 +: 32] = access_cnt[b];
  end
`endif

endmodule

// File: tb/tb_tpc_sram_arbiter.sv
// Self-checking bench for tpc_sram_arbiter: flat-address reference memory, min-distance round-robin model,
// directed scenarios followed by randomized traffic.
module tb_tpc_sram_arbiter;
  localparam int NR = 3, NB = 4, DEPTH = 256, W = 256, AW = 20, WB = 8;

  logic clk, rst;
  logic [NR-1:0]    req_valid, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*W-1:0]  req_wdata;
  logic [NR-1:0]    req_gnt, rsp_valid;
  logic [NR*W-1:0]  rsp_data;
  logic [NB-1:0]    bank_en, bank_we;
  logic [NB*WB-1:0] bank_word;
  logic [NB*W-1:0]  bank_wdata, bank_rdata;
`ifdef TPC_SRAM_ARB_PERF_EN
  logic [NR*32-1:0] perf_conflict;
  logic [NB*32-1:0] perf_access;
`endif

  tpc_sram_arbiter #(.NUM_REQ(NR), .SRAM_BANKS(NB), .SRAM_DEPTH(DEPTH), .SRAM_WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_en(bank_en), .bank_we(bank_we), .bank_word(bank_word), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
`ifdef TPC_SRAM_ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_access(perf_access)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] initv(input int a);
    logic [W-1:0] v;
    if (a == 32) return W'(4);
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = (a * 32'h9E3779B1) ^ (k * 32'h01000193) ^ 32'h5A5A0000;
    return v;
  endfunction

  function automatic int dbank(input logic [AW-1:0] a);
    int v;
    v = int'(a % 1024);
    return (v % NB) ^ ((v / DEPTH) % NB);
  endfunction

  function automatic int dword(input logic [AW-1:0] a);
    return int'((a % 1024) / NB);
  endfunction

  // Bench-side SRAM banks; contents reinitialised whenever reset is held across an edge.
  logic [W-1:0] sram [NB][DEPTH];
  logic [W-1:0] rq [NB];
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < DEPTH; w++) sram[b][w] <= initv(w * 4 + (b ^ (w / 64)));
    end else begin
      for (int b = 0; b < NB; b++)
        if (bank_en[b]) begin
          if (bank_we[b]) sram[b][bank_word[b*WB +: WB]] <= bank_wdata[b*W +: W];
          else rq[b] <= sram[b][bank_word[b*WB +: WB]];
        end
    end
  end
  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NB; b++) bank_rdata[b*W +: W] = rq[b];
  end

  // Reference model state
  int ptr [NB];
  logic [W-1:0] ref_mem [1024];
  logic [NR-1:0] pend, mgnt;
  logic [W-1:0] pdata [NR];
  int conf_cnt [NR];
  int acc_cnt [NB];
  int errors = 0, checks = 0;

  logic [NR-1:0]    s_gnt, s_rv;
  logic [NB-1:0]    s_en;
  logic [NB*WB-1:0] s_word;
  logic [NR*W-1:0]  s_rd;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin ptr[b] = 0; acc_cnt[b] = 0; end
    for (int r = 0; r < NR; r++) begin conf_cnt[r] = 0; pdata[r] = '0; end
    for (int a = 0; a < 1024; a++) ref_mem[a] = initv(a);
    pend = '0;
    mgnt = '0;
  endtask

  task automatic check_half();
    int win [NB];
    int bestd, d, q, v;
    logic [NR-1:0] eg, npend;
    logic [NB-1:0] een, ewe;
    logic [W-1:0] ndata [NR];
    logic [AW-1:0] a;
    @(negedge clk);
    eg = '0; een = '0; ewe = '0; npend = '0;
    for (int r = 0; r < NR; r++) ndata[r] = '0;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      bestd = NR;
      if (!rst)
        for (int r = 0; r < NR; r++) begin
          a = req_addr[r*AW +: AW];
          if (req_valid[r] && dbank(a) == b) begin
            d = (r - ptr[b] + NR) % NR;
            if (d < bestd) begin bestd = d; win[b] = r; end
          end
        end
      if (win[b] >= 0) begin eg[win[b]] = 1'b1; een[b] = 1'b1; ewe[b] = req_we[win[b]]; end
    end
    check("req_gnt", W'(req_gnt), W'(eg));
    check("bank_en", W'(bank_en), W'(een));
    check("bank_we", W'(bank_we), W'(ewe));
    for (int b = 0; b < NB; b++) begin
      if (win[b] >= 0) begin
        a = req_addr[win[b]*AW +: AW];
        check($sformatf("bank_word[%0d]", b), W'(bank_word[b*WB +: WB]), W'(dword(a)));
        check($sformatf("bank_wdata[%0d]", b), bank_wdata[b*W +: W], req_wdata[win[b]*W +: W]);
      end else begin
        check($sformatf("bank_word[%0d]", b), W'(bank_word[b*WB +: WB]), '0);
        check($sformatf("bank_wdata[%0d]", b), bank_wdata[b*W +: W], '0);
      end
    end
    check("rsp_valid", W'(rsp_valid), W'(pend));
    for (int r = 0; r < NR; r++)
      check($sformatf("rsp_data[%0d]", r), rsp_data[r*W +: W], pend[r] ? pdata[r] : '0);
`ifdef TPC_SRAM_ARB_PERF_EN
    for (int r = 0; r < NR; r++)
      check($sformatf("perf_conflict[%0d]", r), W'(perf_conflict[r*32 +: 32]), W'(conf_cnt[r]));
    for (int b = 0; b < NB; b++)
      check($sformatf("perf_access[%0d]", b), W'(perf_access[b*32 +: 32]), W'(acc_cnt[b]));
`endif
    s_gnt = req_gnt; s_en = bank_en; s_word = bank_word; s_rv = rsp_valid; s_rd = rsp_data;
    mgnt = eg;
    if (!rst) begin
      for (int b = 0; b < NB; b++)
        if (win[b] >= 0) begin
          q = win[b];
          a = req_addr[q*AW +: AW];
          v = int'(a % 1024);
          if (req_we[q]) ref_mem[v] = req_wdata[q*W +: W];
          else begin npend[q] = 1'b1; ndata[q] = ref_mem[v]; end
          ptr[b] = (q + 1) % NR;
          acc_cnt[b]++;
        end
      for (int r = 0; r < NR; r++) if (req_valid[r] && !eg[r]) conf_cnt[r]++;
      pend = npend;
      for (int r = 0; r < NR; r++) pdata[r] = ndata[r];
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check_half();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    check_half();
    check("rst_gnt", W'(s_gnt), '0);
    check("rst_bank_en", W'(s_en), '0);
    check("rst_rsp_valid", W'(s_rv), '0);
`ifdef TPC_SRAM_ARB_PERF_EN
    check("rst_perf_conflict", W'(perf_conflict), '0);
    check("rst_perf_access", W'(perf_access), '0);
`endif
    advance();
    rst = 1'b0;
  endtask

  task automatic set_req(input int r, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [W-1:0] d);
    req_valid[r] = v;
    req_we[r] = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*W +: W] = d;
  endtask

  task automatic new_random_req(input int r);
    logic [W-1:0] d;
    logic [AW-1:0] a;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    a = AW'(($urandom & 32'hFFC00) | ($urandom & 32'h30F));
    set_req(r, 1'b1, ($urandom_range(0, 9) < 3), a, d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    model_reset();

    // Single read of preloaded word; reset also shows gating with a live request
    set_req(0, 1'b1, 1'b0, 20'h00020, '0);
    do_reset();
    step();
    check("t1_gnt", W'(s_gnt), W'(3'b001));
    check("t1_bank_en", W'(s_en), W'(4'b0001));
    check("t1_word", W'(s_word[7:0]), W'(8));
    req_valid = '0;
    step();
    check("t1_rsp_valid", W'(s_rv), W'(3'b001));
    check("t1_rsp_data", W'(s_rd[31:0]), W'(4));

    // Two requesters contending for bank0 alternate
    set_req(0, 1'b1, 1'b0, 20'h00020, '0);
    set_req(1, 1'b1, 1'b0, 20'h00024, '0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_gnt[%0d]", i), W'(s_gnt), (i % 2 == 0) ? W'(3'b001) : W'(3'b010));
      if (i > 0) check($sformatf("t2_rsp[%0d]", i), W'(s_rv), (i % 2 == 1) ? W'(3'b001) : W'(3'b010));
    end
    req_valid = '0;
    step();
`ifdef TPC_SRAM_ARB_PERF_EN
    check("t2_perf_conflict0", W'(perf_conflict[31:0]), W'(2));
    check("t2_perf_conflict1", W'(perf_conflict[63:32]), W'(2));
    check("t2_perf_access0", W'(perf_access[31:0]), W'(4));
`endif

    // Different banks granted together
    set_req(0, 1'b1, 1'b0, 20'h00020, '0);
    set_req(1, 1'b1, 1'b0, 20'h00021, '0);
    step();
    check("t3_gnt", W'(s_gnt), W'(3'b011));
    req_valid = '0;
    step();
    check("t3_rsp_valid", W'(s_rv), W'(3'b011));

    // Swizzle decode
    set_req(0, 1'b1, 1'b0, 20'h00100, '0);
    step();
    check("t4_0x100_en", W'(s_en), W'(4'b0010));
    check("t4_0x100_word", W'(s_word[15:8]), W'(64));
    set_req(0, 1'b1, 1'b0, 20'h00101, '0);
    step();
    check("t4_0x101_en", W'(s_en), W'(4'b0001));
    check("t4_0x101_word", W'(s_word[7:0]), W'(64));
    req_valid = '0;
    step();

    // Write beats read to the same word, read then sees the new data
    set_req(0, 1'b1, 1'b1, 20'h00030, W'(8));
    set_req(1, 1'b1, 1'b0, 20'h00030, '0);
    do_reset();
    step();
    check("t5_gnt_w", W'(s_gnt), W'(3'b001));
    req_valid[0] = 1'b0;
    step();
    check("t5_gnt_r", W'(s_gnt), W'(3'b010));
    req_valid[1] = 1'b0;
    step();
    check("t5_rsp_valid", W'(s_rv), W'(3'b010));
    check("t5_rsp_data", W'(s_rd[W+31:W]), W'(8));

    // Reset lands between a read grant and its response edge
    req_valid = '0;
    do_reset();
    set_req(0, 1'b1, 1'b0, 20'h00020, '0);
    check_half();
    check("t6_gnt", W'(s_gnt), W'(3'b001));
    #2 rst = 1'b1;
    model_reset();
    advance();
    req_valid = '0;
    rst = 1'b0;
    step();
    check("t6_rsp_after_rst", W'(s_rv), '0);
    step();
    check("t6_rsp_late", W'(s_rv), '0);
    set_req(0, 1'b1, 1'b0, 20'h00020, '0);
    set_req(1, 1'b1, 1'b0, 20'h00024, '0);
    step();
    check("t6_rr_from_zero", W'(s_gnt), W'(3'b001));
    req_valid = '0;
    step();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      check_half();
      advance();
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && mgnt[r]) req_valid[r] = 1'b0;
        if (!req_valid[r] && $urandom_range(0, 9) < 6) new_random_req(r);
      end
    end
    req_valid = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
